// File: rtl/clk_divider_multi.sv
// clk_divider_multi: N-channel runtime-programmable clock/tick divider.
// Divisor reloads are staged in div_nxt and applied only at a safe point (TC, stopped or idle).
module clk_divider_multi #(
  parameter int N_CH = 4,
  parameter int CNT_W = 32,
  parameter int unsigned DIV_RST = 130208,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  mode,
  input  logic             ld_valid,
  input  logic [CH_W-1:0]  ld_ch,
  input  logic [CNT_W-1:0] ld_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);
  localparam logic [CNT_W-1:0] DIV_R = CNT_W'(DIV_RST);
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt, div_act, div_nxt;
    logic mode_act, co, tk, pd, run, tc, app, ld;
    assign run = en[c] && (div_act != '0);
    assign tc = run && (cnt == div_act - CNT_W'(1));
    assign app = pd && (tc || !run);
    assign ld = ld_valid && (ld_ch == CH_W'(c));
    // a load in the same cycle as an apply stays pending: the apply takes the old div_nxt
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        div_act <= DIV_R;
        div_nxt <= DIV_R;
        mode_act <= 1'b0;
        co <= 1'b0;
        tk <= 1'b0;
        pd <= 1'b0;
      end else begin
        cnt <= (app || tc) ? '0 : run ? cnt + CNT_W'(1) : cnt;
        div_act <= app ? div_nxt : div_act;
        div_nxt <= ld ? ld_div : div_nxt;
        pd <= ld || (pd && !app);
        mode_act <= tc ? mode[c] : mode_act;
        co <= (div_act == '0 || (app && div_nxt == '0)) ? 1'b0 : tc ? !(mode[c] || mode_act || co) : co;
        tk <= tc && mode[c];
      end
    assign clk_out[c] = co;
    assign tick[c] = tk;
    assign pending[c] = pd;
  end
endmodule
